ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter CTRL_W, default 24: width of one decoded control word (ALUOp, RegWrite, MemWrite, MemRead, MemToReg, RegDst, ALUSrc, LoadData, StoreData, Jmux, etc., packed).
REQ-002 Parameter STAGES, default 3: number of pipeline control stages (ID/EX, EX/MEM, MEM/WB); legal range 1..8.
REQ-003 Parameter CNT_W, default 16: width of each bubble/flush event counter.
REQ-004 Clk  input  1  rising-edge clock; the only clock.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-006 ctrl_in  input  CTRL_W  control word from the decoder for the instruction in ID.
REQ-007 valid_in  input  1  ctrl_in belongs to a real instruction.
REQ-008 stall  input  1  load-use stall: insert a bubble into stage 0.
REQ-009 hold  input  1  global freeze, e.g. multicycle multiply: no stage changes.
REQ-010 flush  input  STAGES  per-stage flush; bit k kills the word entering stage k.
REQ-011 stage_ctrl  output  STAGES*CTRL_W  registered control words; stage k occupies bits [k*CTRL_W +: CTRL_W].
REQ-012 stage_valid  output  STAGES  per-stage valid bit.
REQ-013 bubble_cnt  output  CNT_W  count of bubbles inserted by stall or flush.
REQ-014 retire_cnt  output  CNT_W  count of valid words leaving the last stage.

Function
REQ-015 Every stage register and both counters SHALL update only on the rising Clk edge, with latency exactly one cycle per stage, so ctrl_in reaches stage STAGES-1 after STAGES edges.
REQ-016 Per-edge priority SHALL be: Reset > hold > flush > stall > normal advance.
REQ-017 With hold=1 and Reset=0, every stage and both counters SHALL keep their values, and flush and stall SHALL be ignored that cycle.
REQ-018 In normal advance, stage 0 SHALL load {ctrl_in, valid_in}, and stage k>0 SHALL load stage k-1.
REQ-019 stall=1 with flush[0]=0 SHALL load stage 0 with ctrl=0 and valid=0; stages k>0 SHALL still advance.
REQ-020 flush[k]=1 SHALL load stage k with ctrl=0 and valid=0 instead of its normal input; the other stages SHALL be unaffected.
REQ-021 A bubble SHALL always carry an all-zero control word, so RegWrite, MemWrite and MemRead are deasserted.
REQ-022 bubble_cnt SHALL increment by 1 per advancing edge on which at least one stage is loaded with a bubble caused by stall or flush and the word displaced was valid or was incoming.
  - Simplified rule: increment once per edge where stall=1 or any flush bit=1, with hold=0.
REQ-023 retire_cnt SHALL increment by 1 on each non-hold edge where stage_valid[STAGES-1]=1.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 Simultaneous stall and flush[0] SHALL produce exactly one bubble in stage 0 and one bubble_cnt increment.
REQ-026 valid_in=0 with nonzero ctrl_in SHALL still load ctrl_in; consumers SHALL gate the control word with stage_valid.
REQ-027 For STAGES=1, stage 0 is also the last stage, and REQ-023 SHALL apply to it.
REQ-028 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 Reset=1 at a rising edge SHALL clear all stage_ctrl, stage_valid, bubble_cnt and retire_cnt to 0, regardless of hold, stall or flush.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words; the first valid_in after deassertion SHALL retire after exactly STAGES edges.

Verification
REQ-031 Reset, then valid_in=1 with ctrl_in=24'h00A5C3 on 3 consecutive edges (STAGES=3) -> stage_ctrl[2] = 24'h00A5C3 and stage_valid = 3'b111 after edge 3; retire_cnt = 1 after edge 4.
REQ-032 Stream words W1 and W2; stall=1 on the edge where W2 would enter stage 0 -> stage 0 = 0/invalid, W1 in stage 1, bubble_cnt = 1; W2 SHALL NOT appear (the upstream holds it).
REQ-033 Three valid words in flight, then flush=3'b011 for one edge -> stages 0 and 1 are invalid with zero ctrl, the stage-2 word advances normally, bubble_cnt increments by 1.
REQ-034 hold=1 for 4 edges with stall=1 and flush=3'b111 also asserted -> all outputs unchanged across the 4 edges; normal advance resumes on the first edge after hold=0.
REQ-035 CNT_W=4, 20 consecutive stall edges -> bubble_cnt stops at 4'hF, no wrap.
REQ-036 Reset=1 for one edge while hold=1 and pipe full -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline for the ID/EX..MEM/WB registers.
// Supports hold, per-stage flush and a load-use bubble, with saturating bubble and retire counters.

module ctrl_pipeline_stage #(
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              kill,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic              d_vld,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic              q_vld
);
    // A bubble always carries an all-zero control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_ctrl <= '0;
            q_vld  <= 1'b0;
        end else if (!hold) begin
            if (kill) begin
                q_ctrl <= '0;
                q_vld  <= 1'b0;
            end else begin
                q_ctrl <= d_ctrl;
                q_vld  <= d_vld;
            end
        end
    end
endmodule

module ctrl_pipeline #(
    parameter int CTRL_W = 24,
    parameter int STAGES = 3,   // legal range 1..8
    parameter int CNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic                     valid_in,
    input  logic                     stall,
    input  logic                     hold,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [STAGES-1:0]        stage_valid,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         retire_cnt
);
    // Entry 0 is the decoder input; entry k+1 is the register of stage k.
    logic [STAGES:0][CTRL_W-1:0] ctrl_pipe;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES-1:0]           kill;
    logic                        bubble_evt;
    logic                        retire_evt;

    assign ctrl_pipe[0] = ctrl_in;
    assign vld_pipe[0]  = valid_in;
    // stall and flush[0] merge into a single stage-0 bubble.
    assign kill         = flush | STAGES'(stall);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ctrl_pipeline_stage #(.CTRL_W(CTRL_W)) u_stage (
            .clk    (Clk),
            .reset  (Reset),
            .hold   (hold),
            .kill   (kill[k]),
            .d_ctrl (ctrl_pipe[k]),
            .d_vld  (vld_pipe[k]),
            .q_ctrl (ctrl_pipe[k+1]),
            .q_vld  (vld_pipe[k+1])
        );
    end

    assign stage_ctrl  = ctrl_pipe[STAGES:1];
    assign stage_valid = vld_pipe[STAGES:1];

    assign bubble_evt = !hold && (stall || (|flush));
    assign retire_evt = !hold && vld_pipe[STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bubble_cnt <= '0;
            retire_cnt <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (retire_evt && (retire_cnt != {CNT_W{1'b1}}))
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: a reference model pushes the expected state each edge,
// popped and compared after the edge. A CNT_W=4 copy exercises counter saturation.

module tb_ctrl_pipeline;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [23:0] ctrl_in;
    logic        valid_in;
    logic        stall;
    logic        hold;
    logic [2:0]  flush;

    logic [71:0] stage_ctrl,  stage_ctrl4;
    logic [2:0]  stage_valid, stage_valid4;
    logic [15:0] bubble_cnt,  retire_cnt;
    logic [3:0]  bubble_cnt4, retire_cnt4;

    always #5 Clk = ~Clk;

    ctrl_pipeline dut (
        .Clk(Clk), .Reset(Reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .hold(hold), .flush(flush),
        .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
        .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
    );

    ctrl_pipeline #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .hold(hold), .flush(flush),
        .stage_ctrl(stage_ctrl4), .stage_valid(stage_valid4),
        .bubble_cnt(bubble_cnt4), .retire_cnt(retire_cnt4)
    );

    typedef struct {
        logic [71:0] ctrl;
        logic [2:0]  vld;
        logic [15:0] b;
        logic [15:0] r;
        logic [3:0]  b4;
        logic [3:0]  r4;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] m_ctrl[3];
    logic [2:0]  m_vld;
    logic [15:0] m_b, m_r;
    logic [3:0]  m_b4, m_r4;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic rst, input logic [23:0] c, input logic v,
                        input logic s, input logic h, input logic [2:0] f);
        exp_t        e;
        logic [23:0] n_ctrl[3];
        logic [2:0]  n_vld;
        @(negedge Clk);
        Reset = rst; ctrl_in = c; valid_in = v; stall = s; hold = h; flush = f;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_ctrl[k] = '0;
            m_vld = '0; m_b = '0; m_r = '0; m_b4 = '0; m_r4 = '0;
        end else if (!h) begin
            if (m_vld[2]) begin
                if (m_r != 16'hFFFF) m_r = m_r + 16'd1;
                if (m_r4 != 4'hF)    m_r4 = m_r4 + 4'd1;
            end
            if (s || f != 3'b000) begin
                if (m_b != 16'hFFFF) m_b = m_b + 16'd1;
                if (m_b4 != 4'hF)    m_b4 = m_b4 + 4'd1;
            end
            n_ctrl[0] = (s || f[0]) ? 24'h0 : c;
            n_vld[0]  = (s || f[0]) ? 1'b0 : v;
            for (int k = 1; k < 3; k++) begin
                n_ctrl[k] = f[k] ? 24'h0 : m_ctrl[k-1];
                n_vld[k]  = f[k] ? 1'b0 : m_vld[k-1];
            end
            for (int k = 0; k < 3; k++) m_ctrl[k] = n_ctrl[k];
            m_vld = n_vld;
        end
        e.ctrl = {m_ctrl[2], m_ctrl[1], m_ctrl[0]};
        e.vld = m_vld; e.b = m_b; e.r = m_r; e.b4 = m_b4; e.r4 = m_r4;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("stage_ctrl",   stage_ctrl,   e.ctrl);
        chk("stage_valid",  stage_valid,  e.vld);
        chk("bubble_cnt",   bubble_cnt,   e.b);
        chk("retire_cnt",   retire_cnt,   e.r);
        chk("stage_ctrl4",  stage_ctrl4,  e.ctrl);
        chk("bubble_cnt4",  bubble_cnt4,  e.b4);
        chk("retire_cnt4",  retire_cnt4,  e.r4);
    endtask

    task automatic run(input logic [23:0] c, input logic v);
        step(1'b0, c, v, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic do_reset();
        step(1'b1, 24'h0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        logic [71:0] snap_c;
        logic [2:0]  snap_v;
        logic [15:0] snap_b, snap_r;

        Reset = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = 1'b0; hold = 1'b0; flush = '0;
        do_reset();
        do_reset();
        chk("reset_valid", stage_valid, 3'b000);
        chk("reset_bcnt",  bubble_cnt,  16'd0);

        // Basic fill and retire latency
        for (int i = 0; i < 3; i++) run(24'h00A5C3, 1'b1);
        chk("fill_s2_ctrl", stage_ctrl[71:48], 24'h00A5C3);
        chk("fill_valid",   stage_valid, 3'b111);
        chk("fill_retire0", retire_cnt, 16'd0);
        run(24'h0, 1'b0);
        chk("retire_one",   retire_cnt, 16'd1);

        // Load-use stall
        do_reset();
        run(24'h000111, 1'b1);
        step(1'b0, 24'h000222, 1'b1, 1'b1, 1'b0, 3'b000);
        chk("stall_s0_ctrl", stage_ctrl[23:0],  24'h0);
        chk("stall_s0_vld",  stage_valid[0],    1'b0);
        chk("stall_s1_ctrl", stage_ctrl[47:24], 24'h000111);
        chk("stall_bcnt",    bubble_cnt, 16'd1);

        // Flush of stages 0 and 1
        do_reset();
        run(24'h00000A, 1'b1);
        run(24'h00000B, 1'b1);
        run(24'h00000C, 1'b1);
        step(1'b0, 24'h00000D, 1'b1, 1'b0, 1'b0, 3'b011);
        chk("flush_valid", stage_valid, 3'b100);
        chk("flush_s2",    stage_ctrl[71:48], 24'h00000B);
        chk("flush_low",   stage_ctrl[47:0],  48'h0);
        chk("flush_bcnt",  bubble_cnt, 16'd1);

        // Hold overrides stall and flush
        run(24'h00000E, 1'b1);
        run(24'h00000F, 1'b1);
        snap_c = stage_ctrl; snap_v = stage_valid; snap_b = bubble_cnt; snap_r = retire_cnt;
        for (int i = 0; i < 4; i++) step(1'b0, 24'h123456, 1'b1, 1'b1, 1'b1, 3'b111);
        chk("hold_ctrl", stage_ctrl, snap_c);
        chk("hold_vld",  stage_valid, snap_v);
        chk("hold_bcnt", bubble_cnt, snap_b);
        chk("hold_rcnt", retire_cnt, snap_r);
        run(24'h000010, 1'b1);
        chk("resume_s0", stage_ctrl[23:0], 24'h000010);

        // Invalid word with nonzero control still loads
        run(24'hBADBAD, 1'b0);
        chk("inv_s0_ctrl", stage_ctrl[23:0], 24'hBADBAD);
        chk("inv_s0_vld",  stage_valid[0], 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(($urandom % 60) == 0, 24'($urandom), 1'($urandom),
                 ($urandom % 6) == 0, ($urandom % 8) == 0,
                 (($urandom % 5) == 0) ? 3'($urandom) : 3'b000);

        // Counter saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 3'b000);
        chk("sat_bcnt4", bubble_cnt4, 4'hF);
        chk("sat_bcnt",  bubble_cnt, 16'd20);

        // Reset wins over hold with a full pipe
        for (int i = 0; i < 3; i++) run(24'hFFFFFF, 1'b1);
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 3'b111);
        chk("rst_hold_ctrl", stage_ctrl, 72'h0);
        chk("rst_hold_vld",  stage_valid, 3'b000);
        chk("rst_hold_cnt",  {bubble_cnt, retire_cnt}, 32'h0);

        // First word after reset retires after STAGES edges
        run(24'h0000AB, 1'b1);
        run(24'h0, 1'b0);
        run(24'h0, 1'b0);
        chk("post_rst_s2",   stage_ctrl[71:48], 24'h0000AB);
        run(24'h0, 1'b0);
        chk("post_rst_rcnt", retire_cnt, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
